// File: rtl/trng_pkg.sv
// trng_pkg: shared definitions for the TRNG entropy collector.
//   WORD_WIDTH        - width of one entropy word from the source
//   NUM_WORDS_DEFAULT - default words per assembled block
//   REP_LIMIT_DEFAULT - default repetition-count health-test threshold
//   state_e           - collector FSM state encoding
package trng_pkg;

  localparam int unsigned WORD_WIDTH        = 32;
  localparam int unsigned NUM_WORDS_DEFAULT = 16;
  localparam int unsigned REP_LIMIT_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ACK     = 2'd2,
    ST_FULL    = 2'd3
  } state_e;

endpackage

// File: rtl/trng_rep_test.sv
// trng_rep_test: repetition-count health test on captured entropy words.
//   clk, reset_n - clock, asynchronous active-low reset
//   capture      - strobe: word is being captured this cycle
//   word         - captured entropy word
//   test_mode    - suppresses the fail output (history still tracked)
//   clear        - clears repetition history (counter and previous-valid flag)
//   fail         - combinational pulse in the capture cycle when the run of
//                  identical words reaches REP_LIMIT
module trng_rep_test
  import trng_pkg::*;
#(
  parameter int unsigned REP_LIMIT = REP_LIMIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  capture,
  input  logic [WORD_WIDTH-1:0] word,
  input  logic                  test_mode,
  input  logic                  clear,
  output logic                  fail
);

  logic [WORD_WIDTH-1:0] prev_word_q, prev_word_d;
  logic                  prev_valid_q, prev_valid_d;
  logic [7:0]            rep_ctr_q, rep_ctr_d;
  logic [7:0]            rep_ctr_next;

  always_comb begin
    if (prev_valid_q && (word == prev_word_q)) begin
      rep_ctr_next = (rep_ctr_q == 8'hFF) ? 8'hFF : rep_ctr_q + 8'd1;
    end else begin
      rep_ctr_next = 8'd1;
    end

    fail = capture && !test_mode && (rep_ctr_next >= 8'(REP_LIMIT));

    prev_word_d  = prev_word_q;
    prev_valid_d = prev_valid_q;
    rep_ctr_d    = rep_ctr_q;
    // Captures only happen in COLLECT while clear is an IDLE-time action;
    // if both coincide the new word seeds the history.
    if (capture) begin
      prev_word_d  = word;
      prev_valid_d = 1'b1;
      rep_ctr_d    = rep_ctr_next;
    end else if (clear) begin
      prev_valid_d = 1'b0;
      rep_ctr_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_word_q  <= '0;
      prev_valid_q <= 1'b0;
      rep_ctr_q    <= '0;
    end else begin
      prev_word_q  <= prev_word_d;
      prev_valid_q <= prev_valid_d;
      rep_ctr_q    <= rep_ctr_d;
    end
  end

endmodule

// File: rtl/trng_entropy_collector.sv
// trng_entropy_collector: gathers NUM_WORDS entropy words into one block.
//   clk, reset_n            - clock, asynchronous active-low reset
//   enable, entropy_enabled - collection may run only while both are high
//   test_mode, clear_error  - health-test bypass / sticky error clear
//   entropy_data/valid/ack  - source handshake; ack is a one-cycle pulse
//   block_data/valid/ack    - mixer handshake; word 0 sits in the top slot
//   security_error          - sticky repetition-count failure
//   word_count              - words captured into the current block
module trng_entropy_collector
  import trng_pkg::*;
#(
  parameter int unsigned NUM_WORDS = NUM_WORDS_DEFAULT,
  parameter int unsigned REP_LIMIT = REP_LIMIT_DEFAULT
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              enable,
  input  logic                              test_mode,
  input  logic                              clear_error,
  input  logic                              entropy_enabled,
  input  logic [WORD_WIDTH-1:0]             entropy_data,
  input  logic                              entropy_valid,
  output logic                              entropy_ack,
  output logic [NUM_WORDS*WORD_WIDTH-1:0]   block_data,
  output logic                              block_valid,
  input  logic                              block_ack,
  output logic                              security_error,
  output logic [4:0]                        word_count
);

  localparam int unsigned BLOCK_W = NUM_WORDS * WORD_WIDTH;

  state_e               state_q, state_d;
  logic                 entropy_ack_q, entropy_ack_d;
  logic                 block_valid_q, block_valid_d;
  logic [BLOCK_W-1:0]   block_data_q, block_data_d;
  logic                 security_error_q, security_error_d;
  logic [4:0]           word_count_q, word_count_d;
  logic                 run_ok;
  logic                 capture;
  logic                 rep_fail;

  assign run_ok  = enable && entropy_enabled;
  assign capture = (state_q == ST_COLLECT) && run_ok && entropy_valid;

  trng_rep_test #(
    .REP_LIMIT (REP_LIMIT)
  ) u_rep_test (
    .clk       (clk),
    .reset_n   (reset_n),
    .capture   (capture),
    .word      (entropy_data),
    .test_mode (test_mode),
    .clear     (clear_error),
    .fail      (rep_fail)
  );

  always_comb begin
    state_d          = state_q;
    entropy_ack_d    = 1'b0;
    block_valid_d    = 1'b0;
    block_data_d     = block_data_q;
    word_count_d     = word_count_q;
    // A failure in the same cycle as clear_error must still latch.
    security_error_d = rep_fail ? 1'b1 : (clear_error ? 1'b0 : security_error_q);

    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      if (capture && (word_count_q == 5'(i))) begin
        block_data_d[BLOCK_W-1-WORD_WIDTH*i -: WORD_WIDTH] = entropy_data;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        word_count_d = '0;
        if (run_ok && !security_error_q) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (!run_ok) begin
          state_d      = ST_IDLE;
          word_count_d = '0;
        end else if (entropy_valid) begin
          if (rep_fail) begin
            state_d      = ST_IDLE;
            word_count_d = '0;
          end else begin
            // Count and ack are registered together so both appear in ACK.
            state_d       = ST_ACK;
            entropy_ack_d = 1'b1;
            word_count_d  = word_count_q + 5'd1;
          end
        end
      end
      ST_ACK: begin
        if (word_count_q == 5'(NUM_WORDS)) begin
          state_d       = ST_FULL;
          block_valid_d = 1'b1;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_FULL: begin
        if (block_ack) begin
          state_d      = ST_IDLE;
          word_count_d = '0;
        end else begin
          block_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      entropy_ack_q    <= 1'b0;
      block_valid_q    <= 1'b0;
      block_data_q     <= '0;
      security_error_q <= 1'b0;
      word_count_q     <= '0;
    end else begin
      state_q          <= state_d;
      entropy_ack_q    <= entropy_ack_d;
      block_valid_q    <= block_valid_d;
      block_data_q     <= block_data_d;
      security_error_q <= security_error_d;
      word_count_q     <= word_count_d;
    end
  end

  assign entropy_ack    = entropy_ack_q;
  assign block_valid    = block_valid_q;
  assign block_data     = block_data_q;
  assign security_error = security_error_q;
  assign word_count     = word_count_q;

endmodule

// File: tb/tb_trng_entropy_collector.sv
// tb_trng_entropy_collector: self-checking bench for trng_entropy_collector.
// The source model advances its word whenever an ack is observed; every
// acknowledged word is queued and later compared against the block slots.
module tb_trng_entropy_collector;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable;
  logic         test_mode;
  logic         clear_error;
  logic         entropy_enabled;
  logic [31:0]  entropy_data;
  logic         entropy_valid;
  logic         entropy_ack;
  logic [511:0] block_data;
  logic         block_valid;
  logic         block_ack;
  logic         security_error;
  logic [4:0]   word_count;

  always #5 clk = ~clk;

  trng_entropy_collector #(
    .NUM_WORDS (16),
    .REP_LIMIT (8)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .test_mode       (test_mode),
    .clear_error     (clear_error),
    .entropy_enabled (entropy_enabled),
    .entropy_data    (entropy_data),
    .entropy_valid   (entropy_valid),
    .entropy_ack     (entropy_ack),
    .block_data      (block_data),
    .block_valid     (block_valid),
    .block_ack       (block_ack),
    .security_error  (security_error),
    .word_count      (word_count)
  );

  typedef struct {
    bit          tm;
    bit          constant;
    logic [31:0] base;
    int          exp_acks;
    int          exp_bv;
    int          exp_err;
  } vec_t;

  vec_t        vecs [3];
  logic [31:0] exp_q [$];
  logic [31:0] src_word;
  bit          src_const;
  int          total = 0;
  int          bad   = 0;
  int          cyc, ack_cnt, first_bv, first_err, c0;
  logic [511:0] snap;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One clock: sample outputs 1ns after the rising edge, then advance source.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (entropy_ack) begin
      exp_q.push_back(src_word);
      ack_cnt++;
      if (!src_const) src_word = src_word + 32'd1;
      entropy_data = src_word;
    end
    if (block_valid && first_bv < 0) first_bv = cyc;
    if (security_error && first_err < 0) first_err = cyc;
  endtask

  task automatic do_reset();
    reset_n         = 1'b0;
    enable          = 1'b0;
    entropy_enabled = 1'b0;
    entropy_valid   = 1'b0;
    block_ack       = 1'b0;
    clear_error     = 1'b0;
    test_mode       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic set_source(input bit is_const, input logic [31:0] base);
    src_const    = is_const;
    src_word     = base;
    entropy_data = base;
  endtask

  // Raises enable with valid held high; returns in cycle 0 (first COLLECT).
  task automatic start_run();
    first_bv        = -1;
    first_err       = -1;
    ack_cnt         = 0;
    cyc             = -1;
    enable          = 1'b1;
    entropy_enabled = 1'b1;
    entropy_valid   = 1'b1;
    tick();
  endtask

  task automatic check_block(input string nm);
    logic [31:0] e;
    for (int i = 0; i < 16; i++) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s slot %0d: got no queued word want one", nm, i);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s slot %0d", nm, i), 512'(block_data[511-32*i -: 32]), 512'(e));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{tm: 1'b0, constant: 1'b0, base: 32'h0000_0001, exp_acks: 16, exp_bv: 32, exp_err: -1};
    vecs[1] = '{tm: 1'b1, constant: 1'b1, base: 32'h1122_3344, exp_acks: 16, exp_bv: 32, exp_err: -1};
    vecs[2] = '{tm: 1'b0, constant: 1'b1, base: 32'h1122_3344, exp_acks: 7,  exp_bv: -1, exp_err: 15};

    set_source(1'b0, 32'd0);
    do_reset();
    chk("reset ack",  512'(entropy_ack),    512'(0));
    chk("reset bv",   512'(block_valid),    512'(0));
    chk("reset data", block_data,           '0);
    chk("reset err",  512'(security_error), 512'(0));
    chk("reset wc",   512'(word_count),     512'(0));

    for (int r = 0; r < 3; r++) begin
      do_reset();
      test_mode = vecs[r].tm;
      set_source(vecs[r].constant, vecs[r].base);
      start_run();
      repeat (39) tick();
      chk($sformatf("row%0d acks", r),   512'(ack_cnt),   512'(vecs[r].exp_acks));
      chk($sformatf("row%0d bv cyc", r), 512'(first_bv),  512'(vecs[r].exp_bv));
      chk($sformatf("row%0d err cyc", r), 512'(first_err), 512'(vecs[r].exp_err));
      if (vecs[r].exp_bv >= 0) begin
        check_block($sformatf("row%0d", r));
        chk($sformatf("row%0d wc full", r), 512'(word_count), 512'(16));
        chk($sformatf("row%0d bv held", r), 512'(block_valid), 512'(1));
        block_ack = 1'b1;
        tick();
        block_ack = 1'b0;
        chk($sformatf("row%0d bv drop", r), 512'(block_valid), 512'(0));
      end
    end

    // clear_error then re-collect: another 7 acks, then failure again.
    do_reset();
    set_source(1'b1, 32'h1122_3344);
    start_run();
    repeat (20) tick();
    chk("clr err set", 512'(security_error), 512'(1));
    chk("clr acks1",   512'(ack_cnt),        512'(7));
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    chk("clr err cleared", 512'(security_error), 512'(0));
    c0        = cyc;
    ack_cnt   = 0;
    first_err = -1;
    repeat (25) tick();
    chk("clr acks2",    512'(ack_cnt),   512'(7));
    chk("clr err2 cyc", 512'(first_err), 512'(c0 + 16));
    chk("clr no bv",    512'(first_bv),  512'(-1));

    // Backpressure: block held for 100 cycles, then released.
    do_reset();
    set_source(1'b0, 32'h0000_0001);
    start_run();
    repeat (32) tick();
    chk("bp bv cyc", 512'(first_bv), 512'(32));
    chk("bp acks",   512'(ack_cnt),  512'(16));
    chk("bp word0",  512'(block_data[511:480]), 512'(32'h0000_0001));
    chk("bp word15", 512'(block_data[31:0]),    512'(32'h0000_0010));
    snap    = block_data;
    ack_cnt = 0;
    repeat (100) tick();
    chk("bp no ack",  512'(ack_cnt),     512'(0));
    chk("bp stable",  block_data,        snap);
    chk("bp bv held", 512'(block_valid), 512'(1));
    check_block("bp");
    block_ack = 1'b1;
    tick();
    block_ack = 1'b0;
    chk("bp bv t+1",  512'(block_valid), 512'(0));
    tick();
    chk("bp ack t+2", 512'(entropy_ack), 512'(0));
    tick();
    chk("bp ack t+3", 512'(entropy_ack), 512'(1));

    // Enable drop after 5 captures discards the partial block.
    do_reset();
    set_source(1'b0, 32'h0000_0100);
    start_run();
    repeat (9) tick();
    chk("ed acks5", 512'(ack_cnt),    512'(5));
    chk("ed wc5",   512'(word_count), 512'(5));
    enable = 1'b0;
    repeat (2) tick();
    chk("ed wc0", 512'(word_count), 512'(0));
    repeat (3) tick();
    chk("ed wc idle", 512'(word_count), 512'(0));
    chk("ed no acks", 512'(ack_cnt),    512'(5));
    exp_q.delete();
    start_run();
    repeat (32) tick();
    chk("ed bv cyc", 512'(first_bv), 512'(32));
    chk("ed word0",  512'(block_data[511:480]), 512'(32'h0000_0105));
    check_block("ed");

    // Asynchronous reset after 9 captures.
    do_reset();
    set_source(1'b0, 32'h0000_0200);
    start_run();
    repeat (17) tick();
    chk("rst acks9", 512'(ack_cnt),    512'(9));
    chk("rst wc9",   512'(word_count), 512'(9));
    reset_n = 1'b0;
    #1;
    chk("rst ack",  512'(entropy_ack),    512'(0));
    chk("rst bv",   512'(block_valid),    512'(0));
    chk("rst data", block_data,           '0);
    chk("rst err",  512'(security_error), 512'(0));
    chk("rst wc",   512'(word_count),     512'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    start_run();
    repeat (32) tick();
    chk("rst bv cyc", 512'(first_bv), 512'(32));
    chk("rst word0",  512'(block_data[511:480]), 512'(32'h0000_0209));
    check_block("rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
